// File: rtl/data_ram_responder.sv
// data_ram_responder: word-organised data RAM behind the CPU RAM port.
// Accepts one request at a time, waits WAIT_CYCLES, then applies byte-lane
// writes or returns lane-aligned, zero/sign-extended load data with a
// one-cycle ram_ready pulse.
// Optional feature macro LED_MMIO_EN: the word at LED_ADDR maps to the LED
// register instead of RAM.
module data_ram_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 0,
  parameter logic [ADDR_BITS-3:0] LED_ADDR = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ram_req,
  input  logic [ADDR_BITS-3:0] ram_addr,
  input  logic [31:0]          ram_data_in,
  input  logic [3:0]           ram_sel,
  input  logic                 ram_rw,
  input  logic                 ram_extend_type,
  output logic                 ram_ready,
  output logic [31:0]          ram_data_out,
  output logic [31:0]          led_data_out,
  output logic [15:0]          err_count
);
  localparam int AW    = ADDR_BITS - 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] WLAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    wcnt;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic [3:0]    sel_q;
  logic          rw_q;
  logic          ext_q;

  logic [31:0]   mem [DEPTH];
  logic          led_hit;
  logic [31:0]   cur_word;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic          sel_ok;

`ifdef LED_MMIO_EN
  logic [31:0] led_q;
  assign led_hit      = (addr_q == LED_ADDR);
  assign cur_word     = led_hit ? led_q : mem[addr_q];
  assign led_data_out = led_q;
`else
  assign led_hit      = 1'b0;
  assign cur_word     = mem[addr_q];
  assign led_data_out = 32'h0;
`endif

  // Lane select / extension of the addressed word; flags illegal sel patterns
  always_comb begin
    sel_ok  = 1'b1;
    rd_word = 32'h0;
    case (sel_q)
      4'b1111: rd_word = cur_word;
      4'b0011: rd_word = {{16{ext_q & cur_word[15]}}, cur_word[15:0]};
      4'b1100: rd_word = {{16{ext_q & cur_word[31]}}, cur_word[31:16]};
      4'b0001: rd_word = {{24{ext_q & cur_word[7]}},  cur_word[7:0]};
      4'b0010: rd_word = {{24{ext_q & cur_word[15]}}, cur_word[15:8]};
      4'b0100: rd_word = {{24{ext_q & cur_word[23]}}, cur_word[23:16]};
      4'b1000: rd_word = {{24{ext_q & cur_word[31]}}, cur_word[31:24]};
      default: sel_ok  = 1'b0;
    endcase
  end

  // Merge latched store data into the current word, lane by lane
  always_comb begin
    wr_word = cur_word;
    for (int i = 0; i < 4; i++)
      if (sel_q[i]) wr_word[8*i +: 8] = data_q[8*i +: 8];
  end

  // RAM array is never reset; writes commit only on the RESP edge
  always_ff @(posedge clk) begin
    if (state == RESP && rw_q && sel_ok && !led_hit)
      mem[addr_q] <= wr_word;
  end

  // Request FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wcnt         <= 4'd0;
      addr_q       <= '0;
      data_q       <= 32'h0;
      sel_q        <= 4'h0;
      rw_q         <= 1'b0;
      ext_q        <= 1'b0;
      ram_ready    <= 1'b0;
      ram_data_out <= 32'h0;
      err_count    <= 16'h0;
`ifdef LED_MMIO_EN
      led_q        <= 32'h0;
`endif
    end else begin
      ram_ready <= 1'b0;
      case (state)
        IDLE: if (ram_req) begin
          addr_q <= ram_addr;
          data_q <= ram_data_in;
          sel_q  <= ram_sel;
          rw_q   <= ram_rw;
          ext_q  <= ram_extend_type;
          wcnt   <= 4'd0;
          state  <= (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
        WAIT: begin
          if (wcnt == WLAST) state <= RESP;
          else               wcnt  <= wcnt + 4'd1;
        end
        RESP: begin
          ram_ready    <= 1'b1;
          ram_data_out <= (rw_q || !sel_ok) ? 32'h0 : rd_word;
          if (!sel_ok && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`ifdef LED_MMIO_EN
          if (rw_q && sel_ok && led_hit) led_q <= wr_word;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
